id_decode_pipe: RTL and testbench
=================================

Name: id_decode_pipe

Overview:
Parametrised RV32I decode stage and next generation of the combinational ID block. It decodes the instruction and reads and forwards operands from NFWD bypass ports plus the write-back port. It resolves JAL, JALR and branches in ID with correct signed and unsigned compares. A registered load-use scoreboard generates stalls, and the ID/EX pipeline register is built in with a valid/ready handshake on both sides. It sits between the IF/ID register and EX.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural register count; address width is clog2(NREG)
NFWD, 2, number of bypass ports; index 0 has the highest priority (nearest stage)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_valid_i  in  1  IF/ID holds a valid instruction
pc_i  in  XLEN  instruction PC
inst_i  in  32  instruction word
id_ready_o  out  1  ID accepts the instruction this cycle
reg1_read_o / reg2_read_o  out  1  regfile read enables
reg1_addr_o / reg2_addr_o  out  AW  regfile read addresses (inst[19:15], inst[24:20])
reg1_data_i / reg2_data_i  in  XLEN  regfile read data
fwd_valid_i  in  NFWD  bypass valid per port
fwd_addr_i  in  NFWD*AW  bypass destination addresses, packed
fwd_data_i  in  NFWD*XLEN  bypass data, packed
wb_valid_i  in  1  write-back valid
wb_addr_i  in  AW  write-back address
wb_data_i  in  XLEN  write-back data
ex_ready_i  in  1  EX accepts the ID/EX contents
flush_i  in  1  kill the ID/EX contents and the current ID instruction
ex_valid_o  out  1  registered; ID/EX holds a real instruction
pc_o, reg1_o, reg2_o, imm_o  out  XLEN  registered
opcode_o  out  7  registered
funct3_o  out  3  registered
funct7b_o  out  1  registered; inst[30]
wreg_o  out  1  registered
wd_o  out  AW  registered
jump_o  out  1  combinational; redirect IF
jump_addr_o  out  XLEN  combinational
load_stall_o  out  1  combinational; load-use hazard present

Behaviour:
- Reset: every registered output is 0 and all scoreboard bits are 0. In the same cycle, jump_o=0, load_stall_o=0 and id_ready_o=0.
- Immediates are sign-extended to XLEN.
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'h0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Read enables follow the opcode class: LUI, AUIPC and JAL read nothing; JALR, load and OP-IMM read rs1; branch, store and OP read rs1 and rs2.
- wreg_o=1 for every class except branch and store, and is forced to 0 when rd=0.
- An unknown opcode is treated as a NOP: no reads, wreg_o=0, no jump.
- Operand select per source, first match wins:
  1. address 0 gives 0;
  2. fwd port 0 .. NFWD-1 with valid and address match;
  3. write-back with valid and address match;
  4. regfile data.
- Scoreboard: one pending bit per register. pend_eff[r] = pend[r] & ~(wb_valid_i & wb_addr_i==r).
- hazard = if_valid_i & ((reg1_read_o & pend_eff[rs1]) | (reg2_read_o & pend_eff[rs2])). load_stall_o = hazard.
- adv = ex_ready_i | ~ex_valid_o.
- id_ready_o = adv & ~hazard & ~flush_i.
- fire = if_valid_i & id_ready_o.
- ID/EX register update:
  - when adv holds, it loads the decoded fields on fire;
  - when adv holds without fire, it loads a bubble (ex_valid_o=0 and the other outputs 0);
  - when adv is low, it holds.
  - flush_i forces ex_valid_o=0 next cycle, taking priority over everything except rst.
- Scoreboard update each cycle:
  - clear pend[wb_addr_i] when wb_valid_i;
  - then set pend[rd] when fire & load & rd!=0;
  - if set and clear hit the same register in the same cycle, set wins.
  - flush_i does not clear the scoreboard.
- Jumps, qualified by fire (jump_o=0 otherwise):
  - JAL: jump_o=1, jump_addr_o = pc + immJ.
  - JALR: jump_o=1, jump_addr_o = (rs1 + immI) with bit 0 forced to 0, using the forwarded rs1.
  - Branch: BEQ/BNE test equality; BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare. When taken, jump_addr_o = pc + immB.
  - When jump_o=0, jump_addr_o=0.
- Latency: one cycle from fire to ex_valid_o. A load-use pair costs exactly the cycles until write-back of the load, with no extra bubble when the write-back coincides with the dependent instruction's ID cycle.

Test Plan:
- Reset asserted mid-stream while ex_valid_o=1 -> next cycle ex_valid_o=0, all outputs 0, pend all 0.
- ADDI x1,x0,-5 (0xFFB00093) -> imm_o=0xFFFFFFFB, wreg_o=1, wd_o=1, ex_valid_o=1 one cycle after fire.
- x1=0xFFFFFFFF and x2=1 via fwd port 0, BLT x1,x2,+8 at pc 0x100 -> jump_o=1, jump_addr_o=0x108. BLTU with the same operands -> jump_o=0.
- fwd ports 0 and 1 both target x3 with 0xA and 0xB, plus wb x3=0xC -> reg1_o=0xA. x0 targeted on fwd port 0 with 0x55 -> reg1_o=0.
- LW x5 fires, ADD x6,x5,x5 next -> load_stall_o=1, id_ready_o=0, bubble into EX. wb_valid_i with wb_addr_i=5, wb_data_i=0x77 in a later cycle -> ADD fires that same cycle with reg1_o=reg2_o=0x77.
- ex_ready_i=0 with ex_valid_o=1 -> ID/EX holds and id_ready_o=0. flush_i=1 in the same cycle -> ex_valid_o=0 next cycle and pend unchanged.

Source files
------------

// File: rtl/id_decode_pipe_if.sv
// Purpose: IF/ID -> ID -> ID/EX handshake and registered decode bus of id_decode_pipe.
// Ports: upstream if_valid_i/pc_i/inst_i with id_ready_o back; downstream ex_ready_i/flush_i
//        in, ex_valid_o plus the registered decode fields out. slave = decode stage, master = neighbours.
interface id_decode_pipe_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  // IF/ID side
  logic            if_valid_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     inst_i;
  logic            id_ready_o;
  // EX side control
  logic            ex_ready_i;
  logic            flush_i;
  // ID/EX register contents
  logic            ex_valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] reg1_o;
  logic [XLEN-1:0] reg2_o;
  logic [XLEN-1:0] imm_o;
  logic [6:0]      opcode_o;
  logic [2:0]      funct3_o;
  logic            funct7b_o;
  logic            wreg_o;
  logic [AW-1:0]   wd_o;

  modport slave (
    input  if_valid_i, pc_i, inst_i, ex_ready_i, flush_i,
    output id_ready_o, ex_valid_o, pc_o, reg1_o, reg2_o, imm_o,
           opcode_o, funct3_o, funct7b_o, wreg_o, wd_o
  );

  modport master (
    output if_valid_i, pc_i, inst_i, ex_ready_i, flush_i,
    input  id_ready_o, ex_valid_o, pc_o, reg1_o, reg2_o, imm_o,
           opcode_o, funct3_o, funct7b_o, wreg_o, wd_o
  );
endinterface

// File: rtl/id_decode_pipe.sv
// Purpose: RV32I decode stage with operand bypass, ID-resolved jumps/branches, load-use scoreboard
//          and a built-in ID/EX register. Latency: one cycle from fire to ex_valid_o.
// Ports: io (pipeline handshake + ID/EX bus), regfile read port, NFWD bypass ports, write-back port,
//        jump_o/jump_addr_o redirect and load_stall_o. Backpressure: ID/EX holds while ex_ready_i is low.
module id_decode_pipe #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NFWD = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  id_decode_pipe_if.slave      io,
  output logic                 reg1_read_o,
  output logic                 reg2_read_o,
  output logic [AW-1:0]        reg1_addr_o,
  output logic [AW-1:0]        reg2_addr_o,
  input  logic [XLEN-1:0]      reg1_data_i,
  input  logic [XLEN-1:0]      reg2_data_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD*AW-1:0]   fwd_addr_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 wb_valid_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic                 jump_o,
  output logic [XLEN-1:0]      jump_addr_o,
  output logic                 load_stall_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Operand source priority: x0, bypass ports in index order, write-back, regfile.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [AW-1:0]        addr,
    input logic [XLEN-1:0]      rf_data,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD*AW-1:0]   fa,
    input logic [NFWD*XLEN-1:0] fd,
    input logic                 wv,
    input logic [AW-1:0]        wa,
    input logic [XLEN-1:0]      wdat
  );
    logic [XLEN-1:0] res;
    logic            hit;
    res = rf_data;
    hit = 1'b0;
    if (addr == '0) begin
      res = '0;
      hit = 1'b1;
    end
    for (int i = 0; i < NFWD; i++) begin
      if (!hit && fv[i] && (fa[i*AW +: AW] == addr)) begin
        res = fd[i*XLEN +: XLEN];
        hit = 1'b1;
      end
    end
    if (!hit && wv && (wa == addr)) begin
      res = wdat;
    end
    return res;
  endfunction

  // Instruction fields
  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [AW-1:0]   rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst  = io.inst_i;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign rd    = AW'(inst[11:7]);
  assign rs1   = AW'(inst[19:15]);
  assign rs2   = AW'(inst[24:20]);
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  // Opcode class decode; anything unrecognised falls through as a NOP.
  logic            rd1_en, rd2_en, writes, is_load, is_jal, is_jalr, is_br;
  logic [XLEN-1:0] imm_sel;

  always_comb begin
    rd1_en  = 1'b0;
    rd2_en  = 1'b0;
    writes  = 1'b0;
    is_load = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    is_br   = 1'b0;
    imm_sel = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        writes  = 1'b1;
        imm_sel = imm_u;
      end
      OPC_JAL: begin
        writes  = 1'b1;
        is_jal  = 1'b1;
        imm_sel = imm_j;
      end
      OPC_JALR: begin
        rd1_en  = 1'b1;
        writes  = 1'b1;
        is_jalr = 1'b1;
        imm_sel = imm_i;
      end
      OPC_LOAD: begin
        rd1_en  = 1'b1;
        writes  = 1'b1;
        is_load = 1'b1;
        imm_sel = imm_i;
      end
      OPC_OPIMM: begin
        rd1_en  = 1'b1;
        writes  = 1'b1;
        imm_sel = imm_i;
      end
      OPC_BRANCH: begin
        rd1_en  = 1'b1;
        rd2_en  = 1'b1;
        is_br   = 1'b1;
        imm_sel = imm_b;
      end
      OPC_STORE: begin
        rd1_en  = 1'b1;
        rd2_en  = 1'b1;
        imm_sel = imm_s;
      end
      OPC_OP: begin
        rd1_en  = 1'b1;
        rd2_en  = 1'b1;
        writes  = 1'b1;
      end
      default: ;
    endcase
  end

  logic wreg_dec;
  assign wreg_dec    = writes & (rd != '0);
  assign reg1_read_o = rd1_en;
  assign reg2_read_o = rd2_en;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  // Operands; a source the instruction does not read is presented as 0.
  logic [XLEN-1:0] op1, op2;
  assign op1 = rd1_en ? pick_operand(rs1, reg1_data_i, fwd_valid_i, fwd_addr_i, fwd_data_i,
                                     wb_valid_i, wb_addr_i, wb_data_i) : '0;
  assign op2 = rd2_en ? pick_operand(rs2, reg2_data_i, fwd_valid_i, fwd_addr_i, fwd_data_i,
                                     wb_valid_i, wb_addr_i, wb_data_i) : '0;

  // Scoreboard: a write-back this cycle already satisfies the dependency, so it is
  // masked out of the hazard check rather than waiting for the registered clear.
  logic [NREG-1:0] pend_q, pend_d, pend_eff;
  logic            hazard, adv, fire;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_eff[r] = pend_q[r] & ~(wb_valid_i && (wb_addr_i == AW'(r)));
    end
  end

  assign hazard        = io.if_valid_i & ((rd1_en & pend_eff[rs1]) | (rd2_en & pend_eff[rs2]));
  assign load_stall_o  = ~rst & hazard;
  assign adv           = io.ex_ready_i | ~io.ex_valid_o;
  assign io.id_ready_o = ~rst & adv & ~hazard & ~io.flush_i;
  assign fire          = io.if_valid_i & io.id_ready_o;

  // Clear first, then set, so a load re-targeting the register being written back stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i) begin
      pend_d[wb_addr_i] = 1'b0;
    end
    if (fire && is_load && (rd != '0)) begin
      pend_d[rd] = 1'b1;
    end
  end

  // Branch/jump resolution
  logic            br_taken, jump_hit;
  logic [XLEN-1:0] jump_tgt, jalr_sum;

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (op1 == op2);
      3'b001:  br_taken = (op1 != op2);
      3'b100:  br_taken = ($signed(op1) <  $signed(op2));
      3'b101:  br_taken = ($signed(op1) >= $signed(op2));
      3'b110:  br_taken = (op1 <  op2);
      3'b111:  br_taken = (op1 >= op2);
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum = op1 + imm_i;

  always_comb begin
    jump_hit = 1'b0;
    jump_tgt = '0;
    if (is_jal) begin
      jump_hit = 1'b1;
      jump_tgt = io.pc_i + imm_j;
    end else if (is_jalr) begin
      jump_hit = 1'b1;
      jump_tgt = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_br && br_taken) begin
      jump_hit = 1'b1;
      jump_tgt = io.pc_i + imm_b;
    end
  end

  assign jump_o      = fire & jump_hit;
  assign jump_addr_o = jump_o ? jump_tgt : '0;

  // ID/EX register
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7b_q, funct7b_d, wreg_q, wreg_d;
  logic [AW-1:0]   wd_q, wd_d;

  always_comb begin
    ex_valid_d = ex_valid_q;
    pc_d       = pc_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    imm_d      = imm_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7b_d  = funct7b_q;
    wreg_d     = wreg_q;
    wd_d       = wd_q;
    if (io.flush_i || (adv && !fire)) begin
      // Bubble: flush wins over a stalled EX; an empty slot is also loaded as a bubble.
      ex_valid_d = 1'b0;
      pc_d       = '0;
      reg1_d     = '0;
      reg2_d     = '0;
      imm_d      = '0;
      opcode_d   = '0;
      funct3_d   = '0;
      funct7b_d  = 1'b0;
      wreg_d     = 1'b0;
      wd_d       = '0;
    end else if (adv) begin
      ex_valid_d = 1'b1;
      pc_d       = io.pc_i;
      reg1_d     = op1;
      reg2_d     = op2;
      imm_d      = imm_sel;
      opcode_d   = opc;
      funct3_d   = f3;
      funct7b_d  = inst[30];
      wreg_d     = wreg_dec;
      wd_d       = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      imm_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b_q  <= 1'b0;
      wreg_q     <= 1'b0;
      wd_q       <= '0;
      pend_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      pc_q       <= pc_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      imm_q      <= imm_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7b_q  <= funct7b_d;
      wreg_q     <= wreg_d;
      wd_q       <= wd_d;
      pend_q     <= pend_d;
    end
  end

  assign io.ex_valid_o = ex_valid_q;
  assign io.pc_o       = pc_q;
  assign io.reg1_o     = reg1_q;
  assign io.reg2_o     = reg2_q;
  assign io.imm_o      = imm_q;
  assign io.opcode_o   = opcode_q;
  assign io.funct3_o   = funct3_q;
  assign io.funct7b_o  = funct7b_q;
  assign io.wreg_o     = wreg_q;
  assign io.wd_o       = wd_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
module tb_id_decode_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        reg1_read, reg2_read;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        jump;
  logic [31:0] jump_addr;
  logic        load_stall;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADDI_M5 = 32'hFFB00093; // addi x1,x0,-5
  localparam logic [31:0] I_LW_X5   = 32'h00002283; // lw   x5,0(x0)
  localparam logic [31:0] I_ADD_X6  = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] I_JAL     = 32'h010000EF; // jal  x1,+16
  localparam logic [31:0] I_JALR    = 32'h00508067; // jalr x0,5(x1)
  localparam logic [31:0] I_SW      = 32'hFE20AE23; // sw   x2,-4(x1)
  localparam logic [31:0] I_LUI     = 32'h123451B7; // lui  x3,0x12345
  localparam logic [31:0] I_SUB     = 32'h403100B3; // sub  x1,x2,x3
  localparam logic [31:0] I_FWD3    = 32'h00018393; // addi x7,x3,0
  localparam logic [31:0] I_FWD0    = 32'h00000393; // addi x7,x0,0

  id_decode_pipe_if #(.XLEN(32), .AW(5)) io ();

  id_decode_pipe #(.XLEN(32), .NREG(32), .NFWD(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (io),
    .reg1_read_o  (reg1_read),
    .reg2_read_o  (reg2_read),
    .reg1_addr_o  (reg1_addr),
    .reg2_addr_o  (reg2_addr),
    .reg1_data_i  (reg1_data),
    .reg2_data_i  (reg2_data),
    .fwd_valid_i  (fwd_valid),
    .fwd_addr_i   (fwd_addr),
    .fwd_data_i   (fwd_data),
    .wb_valid_i   (wb_valid),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .jump_o       (jump),
    .jump_addr_o  (jump_addr),
    .load_stall_o (load_stall)
  );

  task automatic set_idle();
    io.if_valid_i = 1'b0;
    io.pc_i       = '0;
    io.inst_i     = 32'h00000013;
    io.ex_ready_i = 1'b1;
    io.flush_i    = 1'b0;
    reg1_data     = '0;
    reg2_data     = '0;
    fwd_valid     = '0;
    fwd_addr      = '0;
    fwd_data      = '0;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    io.if_valid_i = 1'b1;
    io.pc_i       = pc;
    io.inst_i     = inst;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    issue(32'h200, I_JAL);
    tick();
    tick();
    n_checks++; if (io.id_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_id_ready: got %b expected 0", io.id_ready_o); end
    n_checks++; if (jump !== 1'b0) begin n_fail++; $display("FAIL rst_jump: got %b expected 0", jump); end
    n_checks++; if (load_stall !== 1'b0) begin n_fail++; $display("FAIL rst_load_stall: got %b expected 0", load_stall); end
    n_checks++; if (io.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid: got %b expected 0", io.ex_valid_o); end
    n_checks++; if (io.imm_o !== 32'h0) begin n_fail++; $display("FAIL rst_imm: got %h expected 0", io.imm_o); end
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    issue(32'h40, I_LW_X5);
    tick();
    n_checks++; if (io.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 1", io.ex_valid_o); end
    rst = 1'b1;
    issue(32'h44, I_ADD_X6);
    #1;
    n_checks++; if (io.id_ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_id_ready: got %b expected 0", io.id_ready_o); end
    tick();
    n_checks++; if (io.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ex_valid: got %b expected 0", io.ex_valid_o); end
    n_checks++; if ({io.pc_o, io.opcode_o, io.wd_o, io.wreg_o, io.funct3_o} !== '0) begin n_fail++; $display("FAIL rmid_fields: got pc %h opc %h wd %h expected 0", io.pc_o, io.opcode_o, io.wd_o); end
    rst = 1'b0;
    #1;
    // Scoreboard was cleared by reset, so the dependent add must not stall.
    n_checks++; if (load_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_pend_clear: got %b expected 0", load_stall); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_addi();
    issue(32'h10, I_ADDI_M5);
    #1;
    n_checks++; if ({reg1_read, reg2_read} !== 2'b10) begin n_fail++; $display("FAIL addi_reads: got %b expected 10", {reg1_read, reg2_read}); end
    n_checks++; if (io.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_pre_valid: got %b expected 0", io.ex_valid_o); end
    tick();
    set_idle();
    n_checks++; if (io.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", io.ex_valid_o); end
    n_checks++; if (io.imm_o !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_imm: got %h expected fffffffb", io.imm_o); end
    n_checks++; if ({io.wreg_o, io.wd_o} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL addi_wd: got %b/%0d expected 1/1", io.wreg_o, io.wd_o); end
    n_checks++; if ({io.opcode_o, io.funct3_o, io.pc_o} !== {7'h13, 3'd0, 32'h10}) begin n_fail++; $display("FAIL addi_fields: got opc %h f3 %0d pc %h", io.opcode_o, io.funct3_o, io.pc_o); end
    tick();
    n_checks++; if (io.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_bubble: got %b expected 0", io.ex_valid_o); end
  endtask

  task automatic test_branch();
    logic [31:0] insts [6];
    logic [31:0] x2v [6];
    logic        exp_j [6];
    insts = '{32'h0020C463, 32'h0020E463, 32'h0020D463, 32'h0020F463, 32'h00208463, 32'h00209463};
    x2v   = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_j = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // blt bltu bge bgeu beq bne
    for (int i = 0; i < 6; i++) begin
      issue(32'h100, insts[i]);
      fwd_valid = 2'b11;
      fwd_addr  = {5'd2, 5'd1};
      fwd_data  = {x2v[i], 32'hFFFFFFFF};
      #1;
      n_checks++; if (jump !== exp_j[i]) begin n_fail++; $display("FAIL br%0d_jump: got %b expected %b", i, jump, exp_j[i]); end
      n_checks++; if (jump_addr !== (exp_j[i] ? 32'h108 : 32'h0)) begin n_fail++; $display("FAIL br%0d_addr: got %h expected %h", i, jump_addr, exp_j[i] ? 32'h108 : 32'h0); end
      tick();
      n_checks++; if ({io.reg1_o, io.reg2_o, io.imm_o} !== {32'hFFFFFFFF, x2v[i], 32'h8}) begin n_fail++; $display("FAIL br%0d_ops: got %h %h %h", i, io.reg1_o, io.reg2_o, io.imm_o); end
    end
    n_checks++; if (io.wreg_o !== 1'b0) begin n_fail++; $display("FAIL br_wreg: got %b expected 0", io.wreg_o); end
    set_idle();
    tick();
  endtask

  task automatic test_fwd_priority();
    logic [1:0]  fv [6];
    logic        wv [6];
    logic [31:0] exp_v [6];
    fv    = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
    wv    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_v = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hA, 32'hB};
    for (int i = 0; i < 6; i++) begin
      issue(32'h80, I_FWD3);
      fwd_valid = fv[i];
      fwd_addr  = {5'd3, 5'd3};
      fwd_data  = {32'hB, 32'hA};
      wb_valid  = wv[i];
      wb_addr   = 5'd3;
      wb_data   = 32'hC;
      reg1_data = 32'hD;
      tick();
      n_checks++; if (io.reg1_o !== exp_v[i]) begin n_fail++; $display("FAIL fwd%0d_reg1: got %h expected %h", i, io.reg1_o, exp_v[i]); end
    end
    issue(32'h84, I_FWD0);
    fwd_valid = 2'b01;
    fwd_addr  = {5'd0, 5'd0};
    fwd_data  = {32'h0, 32'h55};
    reg1_data = 32'h99;
    tick();
    n_checks++; if (io.reg1_o !== 32'h0) begin n_fail++; $display("FAIL fwd_x0: got %h expected 0", io.reg1_o); end
    set_idle();
    tick();
  endtask

  task automatic test_jumps();
    issue(32'h200, I_JAL);
    #1;
    n_checks++; if ({jump, jump_addr} !== {1'b1, 32'h210}) begin n_fail++; $display("FAIL jal_target: got %b %h expected 1 210", jump, jump_addr); end
    tick();
    n_checks++; if ({io.imm_o, io.wreg_o, io.wd_o} !== {32'h10, 1'b1, 5'd1}) begin n_fail++; $display("FAIL jal_fields: got imm %h wreg %b wd %0d", io.imm_o, io.wreg_o, io.wd_o); end
    issue(32'h300, I_JALR);
    reg1_data = 32'h1000;
    #1;
    n_checks++; if ({jump, jump_addr} !== {1'b1, 32'h1004}) begin n_fail++; $display("FAIL jalr_target: got %b %h expected 1 1004", jump, jump_addr); end
    tick();
    n_checks++; if ({io.wreg_o, io.reg1_o} !== {1'b0, 32'h1000}) begin n_fail++; $display("FAIL jalr_fields: got wreg %b reg1 %h", io.wreg_o, io.reg1_o); end
    set_idle();
    tick();
  endtask

  task automatic test_formats();
    issue(32'h400, I_SW);
    #1;
    n_checks++; if ({reg1_read, reg2_read, reg1_addr, reg2_addr} !== {2'b11, 5'd1, 5'd2}) begin n_fail++; $display("FAIL sw_reads: got %b%b %0d %0d", reg1_read, reg2_read, reg1_addr, reg2_addr); end
    tick();
    n_checks++; if ({io.imm_o, io.wreg_o, io.funct3_o} !== {32'hFFFFFFFC, 1'b0, 3'd2}) begin n_fail++; $display("FAIL sw_fields: got imm %h wreg %b f3 %0d", io.imm_o, io.wreg_o, io.funct3_o); end
    issue(32'h404, I_LUI);
    #1;
    n_checks++; if ({reg1_read, reg2_read} !== 2'b00) begin n_fail++; $display("FAIL lui_reads: got %b expected 00", {reg1_read, reg2_read}); end
    tick();
    n_checks++; if ({io.imm_o, io.wreg_o, io.wd_o} !== {32'h12345000, 1'b1, 5'd3}) begin n_fail++; $display("FAIL lui_fields: got imm %h wreg %b wd %0d", io.imm_o, io.wreg_o, io.wd_o); end
    issue(32'h408, I_SUB);
    tick();
    n_checks++; if ({io.funct7b_o, io.opcode_o} !== {1'b1, 7'h33}) begin n_fail++; $display("FAIL sub_f7b: got %b %h expected 1 33", io.funct7b_o, io.opcode_o); end
    issue(32'h40C, 32'hFFFFFFFF);
    #1;
    n_checks++; if ({reg1_read, reg2_read, jump} !== 3'b000) begin n_fail++; $display("FAIL unk_ctrl: got %b expected 000", {reg1_read, reg2_read, jump}); end
    tick();
    n_checks++; if ({io.wreg_o, io.imm_o} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL unk_fields: got wreg %b imm %h", io.wreg_o, io.imm_o); end
    set_idle();
    tick();
  endtask

  task automatic test_load_use();
    issue(32'h500, I_LW_X5);
    #1;
    n_checks++; if (io.id_ready_o !== 1'b1) begin n_fail++; $display("FAIL lu_lw_ready: got %b expected 1", io.id_ready_o); end
    tick();
    n_checks++; if ({io.ex_valid_o, io.wd_o} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL lu_lw_ex: got %b %0d", io.ex_valid_o, io.wd_o); end
    issue(32'h504, I_ADD_X6);
    reg1_data = 32'h11;
    reg2_data = 32'h11;
    #1;
    n_checks++; if ({load_stall, io.id_ready_o} !== 2'b10) begin n_fail++; $display("FAIL lu_stall1: got %b expected 10", {load_stall, io.id_ready_o}); end
    tick();
    n_checks++; if (io.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b expected 0", io.ex_valid_o); end
    n_checks++; if (load_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall2: got %b expected 1", load_stall); end
    tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 32'h77;
    #1;
    n_checks++; if ({load_stall, io.id_ready_o} !== 2'b01) begin n_fail++; $display("FAIL lu_release: got %b expected 01", {load_stall, io.id_ready_o}); end
    tick();
    n_checks++; if ({io.ex_valid_o, io.reg1_o, io.reg2_o, io.wd_o} !== {1'b1, 32'h77, 32'h77, 5'd6}) begin n_fail++; $display("FAIL lu_add_ex: got %b %h %h %0d", io.ex_valid_o, io.reg1_o, io.reg2_o, io.wd_o); end
    // Load re-targets x5 in the same cycle x5 is written back: the set must win.
    issue(32'h508, I_LW_X5);
    tick();
    wb_valid = 1'b0;
    issue(32'h50C, I_ADD_X6);
    #1;
    n_checks++; if (load_stall !== 1'b1) begin n_fail++; $display("FAIL lu_set_wins: got %b expected 1", load_stall); end
    tick();
    wb_valid = 1'b1;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_hold_flush();
    issue(32'h40, I_LW_X5);
    io.ex_ready_i = 1'b0;
    tick();
    issue(32'h200, I_JAL);
    #1;
    n_checks++; if ({io.id_ready_o, jump, jump_addr} !== {1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL hold_ready: got %b %b %h expected 0 0 0", io.id_ready_o, jump, jump_addr); end
    tick();
    n_checks++; if ({io.ex_valid_o, io.opcode_o, io.pc_o, io.wd_o} !== {1'b1, 7'h03, 32'h40, 5'd5}) begin n_fail++; $display("FAIL hold_regs: got %b %h %h %0d", io.ex_valid_o, io.opcode_o, io.pc_o, io.wd_o); end
    io.flush_i = 1'b1;
    #1;
    n_checks++; if (io.id_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", io.id_ready_o); end
    tick();
    n_checks++; if (io.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", io.ex_valid_o); end
    io.flush_i    = 1'b0;
    io.ex_ready_i = 1'b1;
    issue(32'h44, I_ADD_X6);
    #1;
    n_checks++; if (load_stall !== 1'b1) begin n_fail++; $display("FAIL flush_pend_kept: got %b expected 1", load_stall); end
    tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    tick();
    set_idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_addi();
    test_branch();
    test_fwd_priority();
    test_jumps();
    test_formats();
    test_load_use();
    test_hold_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
